// File: rtl/cs_pkg.sv
// cs_pkg: constants and types shared by the CS window core and its neighbouring stages
package cs_pkg;
    localparam int WIN_LEN = 9;
    localparam int X_W = 8;
    localparam int Y_W = 10;
    typedef logic [Y_W-1:0] cs_y_t;
endpackage

// File: rtl/cs_y_collector_if.sv
// cs_y_collector_if: valid/ready result stream; carries a sequence tag when CS_YCOL_SEQ_EN is defined
interface cs_y_collector_if
`ifdef CS_YCOL_SEQ_EN
    #(parameter int SEQ_W = 8)
`endif
    ;
    import cs_pkg::*;
    logic valid;
    logic ready;
    cs_y_t data;
`ifdef CS_YCOL_SEQ_EN
    logic [SEQ_W-1:0] seq;
`endif
    modport master (
        output valid,
        output data,
`ifdef CS_YCOL_SEQ_EN
        output seq,
`endif
        input ready
    );
    modport slave (
        input valid,
        input data,
`ifdef CS_YCOL_SEQ_EN
        input seq,
`endif
        output ready
    );
endinterface

// File: rtl/cs_ycol_fifo.sv
// cs_ycol_fifo: synchronous FIFO with a registered head output that holds its value while empty
module cs_ycol_fifo #(
    parameter int DW = 10,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic [DW-1:0] mem [DEPTH];
    logic wr_en, rd_en;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign wr_n = clr ? '0 : wr_ptr + {{AW{1'b0}}, wr_en};
    assign rd_n = clr ? '0 : rd_ptr + {{AW{1'b0}}, rd_en};
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr[AW-1:0]] <= din;
    end
    // Head is reloaded whenever the FIFO stays non-empty; an entry written this edge bypasses mem
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout <= '0;
        end else begin
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            if (wr_n != rd_n) dout <= (wr_en && rd_n == wr_ptr) ? din : mem[rd_n[AW-1:0]];
        end
    end
endmodule

// File: rtl/cs_y_collector.sv
// cs_y_collector: qualifies CS Y results by window fill and queues them on a valid/ready stream
// Defining CS_YCOL_SEQ_EN adds a per-attempt sequence tag (out.seq) stored alongside each result.
module cs_y_collector
    import cs_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef CS_YCOL_SEQ_EN
  , parameter int SEQ_W = 8
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    x_valid,
    input  cs_y_t                   y_in,
    input  logic                    clr,
    cs_y_collector_if.master        out,
    output logic                    ovf,
    output logic [7:0]              drop_cnt
);
    localparam int FC_W = $clog2(WIN_LEN + 1);
`ifdef CS_YCOL_SEQ_EN
    localparam int DW = Y_W + SEQ_W;
`else
    localparam int DW = Y_W;
`endif
    logic [FC_W-1:0] fill_cnt;
    logic win_full, full, empty, push_due, pop, push, drop;
    logic [DW-1:0] din, dout;
    assign push_due = win_full & ~clr;
    assign pop = ~empty & out.ready & ~clr;
    assign push = push_due & (~full | pop);
    assign drop = push_due & full & ~pop;
    // Any non-sample shifted into CS corrupts the window, so the count restarts from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_cnt <= '0;
            win_full <= 1'b0;
            ovf <= 1'b0;
            drop_cnt <= '0;
        end else begin
            fill_cnt <= (clr || !x_valid) ? '0 : (fill_cnt == FC_W'(WIN_LEN)) ? fill_cnt : fill_cnt + 1'b1;
            win_full <= !clr && x_valid && fill_cnt >= FC_W'(WIN_LEN - 1);
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end
`ifdef CS_YCOL_SEQ_EN
    logic [SEQ_W-1:0] seq_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) seq_cnt <= '0;
        else seq_cnt <= clr ? '0 : seq_cnt + SEQ_W'(push_due);
    end
    assign din = {seq_cnt, y_in};
    assign out.seq = dout[DW-1:Y_W];
`else
    assign din = y_in;
`endif
    assign out.data = dout[Y_W-1:0];
    assign out.valid = ~empty;
    cs_ycol_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .push(push),
        .pop(pop),
        .din(din),
        .dout(dout),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_cs_y_collector.sv
// tb_cs_y_collector: directed bench; y_in carries the edge index so queued results identify their capture edge
module tb_cs_y_collector;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x_valid = 1'b0;
    logic clr = 1'b0;
    logic [9:0] y_in = '0;
    logic ovf;
    logic [7:0] drop_cnt;
    int total = 0;
    int bad = 0;
`ifdef CS_YCOL_SEQ_EN
    cs_y_collector_if #(.SEQ_W(8)) out_if ();
`else
    cs_y_collector_if out_if ();
`endif
    cs_y_collector #(.DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .x_valid(x_valid),
        .y_in(y_in),
        .clr(clr),
        .out(out_if),
        .ovf(ovf),
        .drop_cnt(drop_cnt)
    );
    always #5 clk = ~clk;
    task automatic cyc(input logic xv, input int y, input logic rdy, input logic c);
        x_valid = xv;
        y_in = 10'(y);
        out_if.ready = rdy;
        clr = c;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        out_if.ready = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_if.valid); end
        total++; if (out_if.data !== 10'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", out_if.data); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        total++; if (dut.fill_cnt !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", dut.fill_cnt); end
        reset = 1'b1;
    endtask
    task automatic test_stream();
        for (int k = 1; k <= 9; k++) cyc(1'b1, k, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL stream_e9_valid got=%0b want=0", out_if.valid); end
        for (int k = 10; k <= 12; k++) begin
            cyc(1'b1, k, 1'b1, 1'b0);
            total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'(k)) begin bad++; $display("FAIL stream_e%0d got=%0b/%0d want=1/%0d", k, out_if.valid, out_if.data, k); end
        end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL stream_ovf got=%0b want=0", ovf); end
        cyc(1'b0, 13, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'd13) begin bad++; $display("FAIL stream_last got=%0b/%0d want=1/13", out_if.valid, out_if.data); end
        cyc(1'b0, 14, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b0 || out_if.data !== 10'd13) begin bad++; $display("FAIL stream_hold got=%0b/%0d want=0/13", out_if.valid, out_if.data); end
    endtask
    task automatic test_gap();
        for (int k = 1; k <= 9; k++) cyc(1'b1, k, 1'b1, 1'b0);
        cyc(1'b0, 10, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'd10) begin bad++; $display("FAIL gap_push got=%0b/%0d want=1/10", out_if.valid, out_if.data); end
        total++; if (dut.fill_cnt !== 4'd0) begin bad++; $display("FAIL gap_fill got=%0d want=0", dut.fill_cnt); end
        for (int k = 11; k <= 19; k++) begin
            cyc(1'b1, k, 1'b1, 1'b0);
            total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL gap_refill_e%0d got=%0b want=0", k, out_if.valid); end
        end
        cyc(1'b0, 20, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'd20) begin bad++; $display("FAIL gap_next got=%0b/%0d want=1/20", out_if.valid, out_if.data); end
        cyc(1'b0, 21, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL gap_drain got=%0b want=0", out_if.valid); end
    endtask
    task automatic test_backpressure();
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++) cyc(1'b1, k, 1'b0, 1'b0);
        total++; if (out_if.valid !== 1'b1 || dut.full !== 1'b1) begin bad++; $display("FAIL bp_full got=%0b/%0b want=1/1", out_if.valid, dut.full); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL bp_ovf_early got=%0b want=0", ovf); end
        cyc(1'b1, 18, 1'b0, 1'b0);
        cyc(1'b1, 19, 1'b0, 1'b0);
        cyc(1'b0, 20, 1'b0, 1'b0);
        total++; if (ovf !== 1'b1 || drop_cnt !== 8'd3) begin bad++; $display("FAIL bp_drop got=%0b/%0d want=1/3", ovf, drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'(10 + i)) begin bad++; $display("FAIL bp_drain_%0d got=%0b/%0d want=1/%0d", i, out_if.valid, out_if.data, 10 + i); end
`ifdef CS_YCOL_SEQ_EN
            total++; if (out_if.seq !== 8'(i)) begin bad++; $display("FAIL bp_seq_%0d got=%0d want=%0d", i, out_if.seq, i); end
`endif
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b want=0", out_if.valid); end
`ifdef CS_YCOL_SEQ_EN
        for (int k = 1; k <= 9; k++) cyc(1'b1, k, 1'b1, 1'b0);
        cyc(1'b0, 10, 1'b1, 1'b0);
        total++; if (out_if.valid !== 1'b1 || out_if.seq !== 8'd11) begin bad++; $display("FAIL bp_seq_next got=%0b/%0d want=1/11", out_if.valid, out_if.seq); end
        cyc(1'b0, 0, 1'b1, 1'b0);
`endif
    endtask
    task automatic test_simultaneous();
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 17; k++) cyc(1'b1, k, 1'b0, 1'b0);
        cyc(1'b1, 18, 1'b1, 1'b0);
        total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL sim_drop got=%0d want=3", drop_cnt); end
        total++; if (dut.full !== 1'b1 || out_if.data !== 10'd11) begin bad++; $display("FAIL sim_full got=%0b/%0d want=1/11", dut.full, out_if.data); end
        cyc(1'b0, 0, 1'b0, 1'b1);
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL sim_clr got=%0b want=0", out_if.valid); end
    endtask
    task automatic test_flush();
        for (int k = 1; k <= 14; k++) cyc(1'b1, k, 1'b0, 1'b0);
        total++; if (out_if.valid !== 1'b1 || out_if.data !== 10'd10) begin bad++; $display("FAIL flush_pre got=%0b/%0d want=1/10", out_if.valid, out_if.data); end
        cyc(1'b1, 15, 1'b0, 1'b1);
        total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_if.valid); end
        total++; if (drop_cnt !== 8'd3 || ovf !== 1'b1) begin bad++; $display("FAIL flush_keep got=%0d/%0b want=3/1", drop_cnt, ovf); end
        total++; if (dut.fill_cnt !== 4'd0) begin bad++; $display("FAIL flush_fill got=%0d want=0", dut.fill_cnt); end
    endtask
    task automatic test_reset_mid();
        for (int k = 1; k <= 12; k++) cyc(1'b1, k, 1'b0, 1'b0);
        total++; if (out_if.valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%0b want=1", out_if.valid); end
        #3 reset = 1'b0;
        #1;
        total++; if (out_if.valid !== 1'b0 || out_if.data !== 10'd0) begin bad++; $display("FAIL rmid_out got=%0b/%0d want=0/0", out_if.valid, out_if.data); end
        total++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL rmid_ovf got=%0b/%0d want=0/0", ovf, drop_cnt); end
        #1 reset = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0);
        total++; if (out_if.valid !== 1'b0 || dut.fill_cnt !== 4'd0) begin bad++; $display("FAIL rmid_after got=%0b/%0d want=0/0", out_if.valid, dut.fill_cnt); end
    endtask
    initial begin
        out_if.ready = 1'b0;
        test_reset();
        test_stream();
        test_gap();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
